// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding,
// status word bit positions, CPU read offsets and the parity helper.
// Optional feature macro: SERIAL_TX_PARITY_EN adds the PARITY state.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // Status word layout (upper byte always zero).
  localparam int unsigned STAT_READY_BIT = 0;
  localparam int unsigned STAT_IDLE_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_CNT_LSB   = 3;
  localparam int unsigned STAT_CNT_MSB   = 7;

  // Address offsets relative to the device base: data at base, status at base+1.
  localparam logic ADDR_DATA_OFS   = 1'b0;
  localparam logic ADDR_STATUS_OFS = 1'b1;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// tx_fifo: synchronous byte FIFO with occupancy count and full/empty flags.
// Latency: a pushed entry is visible on pop_dat_o / count_o the next cycle.
// Backpressure: push is ignored when full unless a pop happens on the same edge;
// pop is ignored when empty.
// Ports: clk, rst_n (sync, active low), push_i/push_dat_i, pop_i/pop_dat_o,
// full_o, empty_o, count_o.
module tx_fifo
  import serial_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: CPU-mapped UART transmitter (8 data bits, 1 stop, LSB first) with a TX FIFO.
// Latency: a byte written to an idle line starts its start bit one cycle later; txd is registered.
// Backpressure: writes to a full FIFO are dropped and set the sticky overflow flag (cleared by ack).
// Ports: clk, rst_n (sync, active low), wr/wdata (enqueue), statusordata (1=status, 0=data echo),
// ack (clears overflow), rdata (combinational read word), txd (serial out, idle high).
// Optional macro SERIAL_TX_PARITY_EN: adds an even-parity bit between data and stop.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int CLK_DIV    = 5208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [7:0]  wdata,
  input  logic        statusordata,
  input  logic        ack,
  output logic [15:0] rdata,
  output logic        txd
);

  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  echo_q, echo_d;

  logic          bit_end, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dat;
  logic [CW-1:0] fifo_count;
  logic [15:0]   status;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wr),
    .push_dat_i (wdata),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign bit_end = (baud_q == BAUD_MAX);

  // State register (all sequential state of the transmitter).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      echo_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      echo_q  <= echo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
`ifdef SERIAL_TX_PARITY_EN
      ST_DATA:   if (bit_end && idx_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`else
      ST_DATA:   if (bit_end && idx_q == 3'd7) state_d = ST_STOP;
`endif
      // Back-to-back frames: stop bit flows straight into the next start bit.
      ST_STOP:  if (bit_end) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    pop = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_end));

    // Baud counter restarts at every bit boundary and holds at zero while idle.
    if (state_q == ST_IDLE || bit_end) baud_d = '0;
    else                               baud_d = baud_q + 16'd1;

    // Bit index wraps 7->0 as the last data bit ends.
    idx_d = idx_q;
    if (state_q == ST_DATA && bit_end) idx_d = idx_q + 3'd1;

    byte_d = pop ? fifo_dat : byte_q;

    // txd is decoded from the next state so the line register changes on bit boundaries.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = byte_d[idx_d];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: txd_d = even_parity(byte_q);
`endif
      default:   txd_d = 1'b1;
    endcase

    // An overflowing write wins over a simultaneous ack.
    ovf_d = ovf_q;
    if (ack) ovf_d = 1'b0;
    if (wr && fifo_full && !pop) ovf_d = 1'b1;

    echo_d = (wr && (!fifo_full || pop)) ? wdata : echo_q;
  end

  always_comb begin
    status = '0;
    status[STAT_READY_BIT] = !fifo_full;
    status[STAT_IDLE_BIT]  = fifo_empty && (state_q == ST_IDLE);
    status[STAT_OVF_BIT]   = ovf_q;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(fifo_count);
  end

  always_comb begin
    case (statusordata)
      ADDR_STATUS_OFS: rdata = status;
      ADDR_DATA_OFS:   rdata = {8'h00, echo_q};
      default:         rdata = '0;
    endcase
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_serial_tx;

  localparam int CLK_DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        statusordata = 1'b1;
  logic        ack = 1'b0;
  logic [15:0] rdata;
  logic        txd;

  int errs = 0;
  int checks = 0;
  logic [7:0] strm [5];

  serial_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .wdata        (wdata),
    .statusordata (statusordata),
    .ack          (ack),
    .rdata        (rdata),
    .txd          (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic view(input logic v);
    statusordata = v;
    #1;
  endtask

  // Expected line level for bit slot j of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (NB == 11 && j == 9) return ^b;
    return 1'b1;
  endfunction

  // k counts cycles since the first start-bit edge of a contiguous frame stream.
  task automatic check_txd(input string tag, input int k);
    logic e;
    e = exp_bit(strm[k / FL], (k % FL) / CLK_DIV);
    check($sformatf("%s_k%0d", tag, k), {15'd0, txd}, {15'd0, e});
  endtask

  task automatic single_frame(input string tag, input logic [7:0] b);
    strm[0] = b;
    wr = 1'b1; wdata = b;
    tick();
    wr = 1'b0;
    for (int k = 0; k < FL; k++) begin
      tick();
      check_txd(tag, k);
    end
    tick();
    view(1'b1);
    check({tag, "_idle"}, rdata, 16'h0003);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    view(1'b1);
    check("rst_status", rdata, 16'h0003);
    check("rst_txd", {15'd0, txd}, 16'h0001);
    view(1'b0);
    check("rst_echo", rdata, 16'h0000);
    rst_n = 1'b1;
    tick();

    // 0x55 frame, plus the count=1 status the cycle after the write
    strm[0] = 8'h55;
    wr = 1'b1; wdata = 8'h55;
    tick();
    wr = 1'b0;
    view(1'b1);
    check("w55_status", rdata, 16'h0009);
    check("w55_pre_txd", {15'd0, txd}, 16'h0001);
    for (int k = 0; k < FL; k++) begin
      tick();
      check_txd("f55", k);
    end
    tick();
    check("f55_idle", rdata, 16'h0003);

    // Data echo
    wr = 1'b1; wdata = 8'hA5;
    tick();
    wr = 1'b0;
    view(1'b0);
    check("echo_a5", rdata, 16'h00A5);
    for (int k = 0; k < FL + 1; k++) tick();
    view(1'b1);
    check("a5_idle", rdata, 16'h0003);

    // Five back-to-back writes: contiguous frames, FIFO fills to 4
    strm[0] = 8'h11; strm[1] = 8'h22; strm[2] = 8'h33; strm[3] = 8'h44; strm[4] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wdata = strm[i];
      tick();
      if (i >= 1) check_txd("b2b", i - 1);
      if (i == 4) check("b2b_full", rdata, 16'h0020);
    end
    wr = 1'b0;
    for (int k = 4; k < 5 * FL; k++) begin
      tick();
      check_txd("b2b", k);
    end
    tick();
    check("b2b_idle", rdata, 16'h0003);

    // Six writes: sixth dropped, overflow sticky until ack
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; wdata = 8'(i + 1);
      tick();
    end
    wr = 1'b0;
    check("ovf_status", rdata, 16'h0024);
    view(1'b0);
    check("ovf_echo", rdata, 16'h0005);
    view(1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_clear", rdata, 16'h0020);

    // Reset discards the queue
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_status", rdata, 16'h0003);

    // Reset during DATA bit 3 of a 0x00 frame with a second byte queued
    strm[0] = 8'h00; strm[1] = 8'h00;
    wr = 1'b1; wdata = 8'h00;
    tick();
    tick();
    wr = 1'b0;
    for (int k = 1; k < 18; k++) tick();
    check("bit3_txd", {15'd0, txd}, 16'h0000);
    rst_n = 1'b0;
    tick();
    check("abort_txd", {15'd0, txd}, 16'h0001);
    check("abort_status", rdata, 16'h0003);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      check($sformatf("quiet_k%0d", k), {15'd0, txd}, 16'h0001);
    end
    check("quiet_status", rdata, 16'h0003);

    // Parity-sensitive bytes (parity slot only exists when enabled)
    single_frame("f07", 8'h07);
    single_frame("f03", 8'h03);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
